// File: rtl/id_stage_param.sv
// Instruction-decode stage: opcode decode, register file with write-through
// bypass, load-use hazard detection and the ID/EXE pipeline register.
module id_stage_param #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 32,
   parameter int INIT_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruction,
   input  logic [31:0]       pc_in,
   input  logic              valid_in,
   input  logic              stall_in,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [4:0]        wb_dest,
   input  logic [DATA_W-1:0] wb_data,
   output logic              hazard_stall,
   output logic [4:0]        src1,
   output logic [4:0]        src2,
   output logic              is_src2_out,
   output logic [DATA_W-1:0] val1,
   output logic [DATA_W-1:0] val2,
   output logic [DATA_W-1:0] reg2_out,
   output logic [4:0]        dest_out,
   output logic [31:0]       pc_out,
   output logic              wb_en_out,
   output logic [1:0]        mem_signal_out,
   output logic [1:0]        branch_type_out,
   output logic [3:0]        exe_cmd_out,
   output logic              valid_out
);
   localparam int REG_AW = $clog2(NUM_REGS);

   function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
      return DATA_W'($signed(v));
   endfunction

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs_idx, rt_idx, wb_idx;
   logic              dec_wb, dec_imm, dec_src2;
   logic [1:0]        dec_mem, dec_br;
   logic [3:0]        dec_exe;

   assign opcode = instruction[31:26];
   assign src1   = instruction[25:21];
   assign src2   = instruction[20:16];
   assign rs_idx = instruction[21 +: REG_AW];
   assign rt_idx = instruction[16 +: REG_AW];
   assign wb_idx = wb_dest[REG_AW-1:0];

   // {wb, mem, br, exe, imm, src2}; unlisted opcodes behave as NOP
   always_comb begin
      {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b0;
      case (opcode)
         6'b000001: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_0000_0_1;
         6'b000011: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_0010_0_1;
         6'b000101: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_0100_0_1;
         6'b000110: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_0101_0_1;
         6'b000111: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_0110_0_1;
         6'b001000: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_0111_0_1;
         6'b001001,
         6'b001010: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_1000_0_1;
         6'b001011: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_1001_0_1;
         6'b001100: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_1010_0_1;
         6'b100000: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_0000_1_0;
         6'b100001: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_00_00_0010_1_0;
         6'b100100: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b1_10_00_0000_1_0;
         6'b100101: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b0_01_00_0000_1_1;
         6'b101000: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b0_00_01_0000_1_0;
         6'b101001: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b0_00_10_0000_1_1;
         6'b101010: {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b0_00_11_0000_1_1;
         default:   {dec_wb, dec_mem, dec_br, dec_exe, dec_imm, dec_src2} = 11'b0;
      endcase
   end

   logic [DATA_W-1:0] rf_q [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            rf_q[i] <= (INIT_MODE == 1) ? DATA_W'(i) : '0;
      end else if (wb_en && wb_idx != '0) begin
         rf_q[wb_idx] <= wb_data;
      end
   end

   // Write-through: a same-cycle write to the read index wins over the array
   logic [DATA_W-1:0] rs_val, rt_val;
   always_comb begin
      rs_val = rf_q[rs_idx];
      if (rs_idx == '0)                         rs_val = '0;
      else if (wb_en && wb_idx == rs_idx)       rs_val = wb_data;
   end
   always_comb begin
      rt_val = rf_q[rt_idx];
      if (rt_idx == '0)                         rt_val = '0;
      else if (wb_en && wb_idx == rt_idx)       rt_val = wb_data;
   end

   logic signed [DATA_W-1:0] imm_ext;
   assign imm_ext = sext16(instruction[15:0]);

   logic              valid_q, wb_q, src2_q;
   logic              valid_d, wb_d, src2_d;
   logic [1:0]        mem_q, br_q, mem_d, br_d;
   logic [3:0]        exe_q, exe_d;
   logic [4:0]        dest_q, dest_d;
   logic [31:0]       pc_q, pc_d;
   logic [DATA_W-1:0] val1_q, val2_q, reg2_q, val1_d, val2_d, reg2_d;
   logic              load_pending, hazard;

   // A load in EXE whose destination is a source of the instruction in ID
   assign load_pending = valid_q && wb_q && (mem_q == 2'b10) && (dest_q[REG_AW-1:0] != '0);
   assign hazard = load_pending && valid_in &&
                   ((dest_q[REG_AW-1:0] == rs_idx) || (dec_src2 && dest_q[REG_AW-1:0] == rt_idx));
   assign hazard_stall = hazard;

   always_comb begin
      valid_d = valid_q; wb_d = wb_q; src2_d = src2_q; mem_d = mem_q; br_d = br_q;
      exe_d = exe_q; dest_d = dest_q; pc_d = pc_q;
      val1_d = val1_q; val2_d = val2_q; reg2_d = reg2_q;
      if (flush || (!stall_in && hazard)) begin
         valid_d = 1'b0; wb_d = 1'b0; src2_d = 1'b0; mem_d = '0; br_d = '0;
         exe_d = '0; dest_d = '0; pc_d = '0;
         val1_d = '0; val2_d = '0; reg2_d = '0;
      end else if (!stall_in) begin
         valid_d = valid_in;
         wb_d    = valid_in & dec_wb;
         src2_d  = valid_in & dec_src2;
         mem_d   = valid_in ? dec_mem : 2'b00;
         br_d    = valid_in ? dec_br  : 2'b00;
         exe_d   = valid_in ? dec_exe : 4'b0000;
         dest_d  = dec_imm ? instruction[20:16] : instruction[15:11];
         pc_d    = pc_in;
         val1_d  = rs_val;
         reg2_d  = rt_val;
         val2_d  = dec_imm ? imm_ext : rt_val;
      end
   end

   // ID/EXE pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0; wb_q <= 1'b0; src2_q <= 1'b0; mem_q <= '0; br_q <= '0;
         exe_q <= '0; dest_q <= '0; pc_q <= '0;
         val1_q <= '0; val2_q <= '0; reg2_q <= '0;
      end else begin
         valid_q <= valid_d; wb_q <= wb_d; src2_q <= src2_d; mem_q <= mem_d; br_q <= br_d;
         exe_q <= exe_d; dest_q <= dest_d; pc_q <= pc_d;
         val1_q <= val1_d; val2_q <= val2_d; reg2_q <= reg2_d;
      end
   end

   assign valid_out       = valid_q;
   assign wb_en_out       = wb_q;
   assign is_src2_out     = src2_q;
   assign mem_signal_out  = mem_q;
   assign branch_type_out = br_q;
   assign exe_cmd_out     = exe_q;
   assign dest_out        = dest_q;
   assign pc_out          = pc_q;
   assign val1            = val1_q;
   assign val2            = val2_q;
   assign reg2_out        = reg2_q;

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised instruction-decode stage for the 5-stage pipeline. It sits between the IF stage register and EXE.
- Contains the decode controller, a DATA_W x NUM_REGS register file with write-through bypass, sign-extend and operand muxes.
- Has built-in load-use hazard detection with bubble insertion.
- Its ID/EXE pipeline register supports hold (downstream stall), flush and a valid bit.

Parameters:
- DATA_W, 32, datapath/register width (16..64). Immediate is sign-extended to DATA_W.
- NUM_REGS, 32, register count (power of 2, 2..32). REG_AW=log2(NUM_REGS). Register-select fields use their low REG_AW bits.
- INIT_MODE, 1, reset contents of the register file: 0 = all zero; 1 = r[i]=i.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- instruction  in  32  fetched instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
- pc_in  in  32  PC from IF.
- valid_in  in  1  IF output holds a real instruction.
- stall_in  in  1  downstream stall: hold the ID/EXE register.
- flush  in  1  branch taken: squash the ID/EXE register.
- wb_en  in  1  register-file write enable.
- wb_dest  in  5  write index.
- wb_data  in  DATA_W  write data.
- hazard_stall  out  1  combinational load-use stall request to the PC/IF register.
- src1, src2  out  5  rs/rt fields, combinational, for the forwarding unit.
- is_src2_out  out  1  registered: rt is a true source.
- val1, val2, reg2_out  out  DATA_W  registered rs value, ALU operand 2 (rt value or imm), rt value (store data).
- dest_out  out  5  registered destination: rd for R-type, rt for immediate forms.
- pc_out  out  32  registered PC.
- wb_en_out  out  1  registered write-back enable.
- mem_signal_out  out  2  registered {mem_read, mem_write}.
- branch_type_out  out  2  registered: 00 none, 01 BEZ, 10 BNE, 11 JMP.
- exe_cmd_out  out  4  registered ALU command.
- valid_out  out  1  registered: stage holds a real instruction.

Behaviour:
- Decode (opcode -> wb, mem, br, exe, imm, src2). Any opcode not listed decodes as NOP (all zero).
  - NOP 000000 -> 0,00,00,0000,0,0
  - ADD 000001 -> 1,00,00,0000,0,1
  - SUB 000011 -> 1,00,00,0010,0,1
  - AND 000101 -> 1,00,00,0100,0,1
  - OR 000110 -> 1,00,00,0101,0,1
  - NOR 000111 -> 1,00,00,0110,0,1
  - XOR 001000 -> 1,00,00,0111,0,1
  - SLA 001001 and SLL 001010 -> 1,00,00,1000,0,1
  - SRA 001011 -> 1,00,00,1001,0,1
  - SRL 001100 -> 1,00,00,1010,0,1
  - ADDI 100000 -> 1,00,00,0000,1,0
  - SUBI 100001 -> 1,00,00,0010,1,0
  - LD 100100 -> 1,10,00,0000,1,0
  - ST 100101 -> 0,01,00,0000,1,1
  - BEZ 101000 -> 0,00,01,0000,1,0
  - BNE 101001 -> 0,00,10,0000,1,1
  - JMP 101010 -> 0,00,11,0000,1,1
- Register file:
  - Write on posedge when wb_en=1 and wb_dest[REG_AW-1:0]!=0.
  - Register 0 always reads 0.
  - Reads are combinational with bypass: if wb_en and the write index equals the read index (nonzero), the read returns wb_data in the same cycle.
  - Async reset reloads the INIT_MODE contents.
- hazard_stall=1 when all of the following hold:
  - valid_out=1, wb_en_out=1, mem_signal_out=10;
  - dest_out!=0;
  - dest_out equals rs, or equals rt with the current decode's src2=1;
  - valid_in=1.
- ID/EXE register update priority, evaluated each posedge:
  1. rst (async): all outputs 0, valid_out=0.
  2. flush: all outputs 0, valid_out=0.
  3. stall_in: hold every output.
  4. hazard_stall: insert a bubble (all control and data outputs 0, valid_out=0). IF must hold.
  5. Otherwise load the decoded values with valid_out=valid_in. Control fields are forced to 0 when valid_in=0.
- Latency: one cycle from instruction to registered outputs.
- flush overrides stall_in and hazard. stall_in overrides hazard: no bubble is inserted while held.
- Reset mid-operation clears the pipeline register and register-file contents immediately, without waiting for clk.

Test Plan:
- Reset with INIT_MODE=1, then ADD r3,r1,r2 (rs=1, rt=2, rd=3) with valid_in=1 -> next cycle val1=1, val2=2, dest_out=3, exe_cmd_out=0000, wb_en_out=1, valid_out=1.
- ADDI rt=4, rs=5, imm=16'hFFFE, DATA_W=32 -> val2=32'hFFFFFFFE, dest_out=4, is_src2_out=0.
- wb_en=1, wb_dest=5, wb_data=0x1234 in the same cycle as a decode reading rs=5 -> val1=0x1234. Write with wb_dest=0 -> r0 still reads 0.
- LD into r7, then SUB with rs=7 next cycle -> hazard_stall=1 for one cycle, a bubble is registered (valid_out=0, wb_en_out=0), then SUB issues with valid_out=1.
- stall_in=1 for 3 cycles with changing instruction -> outputs frozen. flush asserted together with stall_in -> valid_out=0 and all outputs 0 next cycle.
- DATA_W=16, NUM_REGS=8, rs field=5'b01010 -> reads r2, val1 is 16 bits. rst pulse between clock edges -> outputs go 0 immediately.
